snn_layer_seq: RTL

- Parametrised layer sequencer for the SNN chip; successor to the single-macro layer controller.
- Drives `N_TILE` CIM macros in parallel from one input spike stream, one time step at a time.
- Per step: assembles the full input spike vector from narrow beats, fires all tiles, collects every tile's neuron outputs, then streams them out with backpressure.
- Sits between the chip I/O (or the previous layer) and the `CIM_MACRO` instances.

---
 rtl/snn_layer_pkg.sv | 33 +++
 rtl/snn_out_buf.sv | 79 +++++++
 rtl/snn_layer_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/snn_layer_pkg.sv
// Shared types and sizing helpers for the SNN layer sequencer.
package snn_layer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_DRAIN
  } state_t;

  // cfg register layout is {PD, SWP, T_MAX}
  localparam int CFG_TMAX_LSB = 0;

  function automatic int cfg_swp_bit(input int t_width);
    return t_width;
  endfunction

  function automatic int cfg_pd_bit(input int t_width);
    return t_width + 1;
  endfunction

  // narrow beats needed to assemble one input spike vector
  function automatic int in_beats(input int n_in, input int io_width);
    return n_in / io_width;
  endfunction

  // narrow beats needed to stream out every tile's neuron outputs
  function automatic int out_beats(input int n_tile, input int neu, input int io_width);
    return (n_tile * neu) / io_width;
  endfunction

endpackage

// File: rtl/snn_out_buf.sv
// Per-step neuron output buffer: captures each tile's slice once, then
// serialises the whole buffer LSB beat first with valid/ready.
module snn_out_buf
  import snn_layer_pkg::*;
#(
  parameter int IO_WIDTH = 8,
  parameter int N_TILE   = 2,
  parameter int NEU      = 16
) (
  input  logic                     gclk,
  input  logic                     grst_n,
  input  logic                     clr,
  input  logic                     cap,
  input  logic                     force_zero,
  input  logic                     drain,
  input  logic                     out_ready,
  input  logic [N_TILE-1:0]        req,
  input  logic [N_TILE*NEU-1:0]    neuron_out,
  output logic                     all_done,
  output logic                     out_valid,
  output logic [IO_WIDTH-1:0]      out_spike,
  output logic                     last_acc
);

  localparam int OUT_BEATS = out_beats(N_TILE, NEU, IO_WIDTH);
  localparam int OB_W      = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;

  logic [N_TILE*NEU-1:0] obuf, obuf_nxt;
  logic [N_TILE-1:0]     done, done_nxt;
  logic [OB_W-1:0]       beat;
  logic                  hs, beat_last;

  // first REQ per tile wins; a forced close fills missing tiles with zeros
  always_comb begin
    obuf_nxt = obuf;
    done_nxt = done;
    if (clr) begin
      done_nxt = '0;
    end else if (cap) begin
      for (int i = 0; i < N_TILE; i++) begin
        if (!done[i] && (req[i] || force_zero)) begin
          obuf_nxt[i*NEU +: NEU] = req[i] ? neuron_out[i*NEU +: NEU] : '0;
          done_nxt[i]            = 1'b1;
        end
      end
    end
  end

  assign all_done  = &done_nxt;
  assign out_valid = drain;
  assign hs        = drain & out_ready;
  assign beat_last = (beat == OB_W'(OUT_BEATS - 1));
  assign last_acc  = hs & beat_last;

  // buffer, done mask and serialiser; beat 0 is preloaded while waiting
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      obuf      <= '0;
      done      <= '0;
      beat      <= '0;
      out_spike <= '0;
    end else begin
      obuf <= obuf_nxt;
      done <= done_nxt;
      if (cap) begin
        beat      <= '0;
        out_spike <= obuf_nxt[IO_WIDTH-1:0];
      end else if (hs) begin
        if (beat_last) begin
          beat <= '0;
        end else begin
          beat      <= beat + OB_W'(1);
          out_spike <= obuf[(int'(beat) + 1)*IO_WIDTH +: IO_WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/snn_layer_seq.sv
// Layer sequencer: assembles input spikes, fires N_TILE CIM macros, gathers
// their outputs and streams them out, once per time step.
// Optional watchdog on the gather phase: SNN_LAYER_SEQ_TIMEOUT_EN.
module snn_layer_seq
  import snn_layer_pkg::*;
#(
  parameter int IO_WIDTH  = 8,
  parameter int N_IN      = 256,
  parameter int N_TILE    = 2,
  parameter int NEU       = 16,
  parameter int T_WIDTH   = 5,
  parameter int WDT_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RSTB,
  input  logic                  RUN,
  input  logic                  CFG_WE,
  input  logic                  CFG_D,
  output logic                  CFG_Q,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [IO_WIDTH-1:0]   IN_SPIKE,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [IO_WIDTH-1:0]   OUT_SPIKE,
  output logic [T_WIDTH-1:0]    T_STEP,
  output logic [N_TILE-1:0]     EN,
  output logic                  FT,
  output logic [N_IN-1:0]       SPIKE_REMAP,
  output logic                  PD_CIM,
  output logic                  SWP,
  input  logic [N_TILE-1:0]     REQ,
  input  logic [N_TILE*NEU-1:0] NEURON_OUT,
  output logic                  ERR
);

  localparam int CFG_W    = T_WIDTH + 2;
  localparam int IN_BEATS = in_beats(N_IN, IO_WIDTH);
  localparam int IB_W     = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
  localparam int PD_BIT   = cfg_pd_bit(T_WIDTH);
  localparam int SWP_BIT  = cfg_swp_bit(T_WIDTH);

  state_t             state, state_nxt;
  logic [CFG_W-1:0]   cfg;
  logic [IB_W-1:0]    in_cnt;
  logic [T_WIDTH-1:0] t_max;
  logic               in_acc, in_last, all_done, last_acc, force_zero;

  assign t_max    = cfg[CFG_TMAX_LSB +: T_WIDTH];
  assign IN_READY = (state == S_LOAD);
  assign in_acc   = IN_READY & IN_VALID;
  assign in_last  = (in_cnt == IB_W'(IN_BEATS - 1));
  assign CFG_Q    = cfg[CFG_W-1];
  assign SWP      = cfg[SWP_BIT];
  assign PD_CIM   = cfg[PD_BIT] | (state == S_IDLE);

  // state register
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state decode; RUN only matters in IDLE so a started run always completes
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (RUN && !CFG_WE) state_nxt = S_LOAD;
      S_LOAD:  if (in_acc && in_last) state_nxt = S_FIRE;
      S_FIRE:  state_nxt = S_WAIT;
      S_WAIT:  if (all_done) state_nxt = S_DRAIN;
      S_DRAIN: if (last_acc) state_nxt = (T_STEP == t_max) ? S_IDLE : S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  // config shift chain, frozen outside IDLE
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB)                          cfg <= '0;
    else if (state == S_IDLE && CFG_WE) cfg <= {cfg[CFG_W-2:0], CFG_D};
  end

  // input beat assembly; the vector persists across steps until overwritten
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      in_cnt      <= '0;
      SPIKE_REMAP <= '0;
    end else if (state != S_LOAD) begin
      in_cnt <= '0;
    end else if (in_acc) begin
      SPIKE_REMAP[in_cnt*IO_WIDTH +: IO_WIDTH] <= IN_SPIKE;
      in_cnt <= in_cnt + IB_W'(1);
    end
  end

  // registered fire strobes and time-step counter
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      EN     <= '0;
      FT     <= 1'b0;
      T_STEP <= '0;
    end else begin
      EN <= {N_TILE{state_nxt == S_FIRE}};
      FT <= (state_nxt == S_FIRE) && (T_STEP == '0);
      if (last_acc) T_STEP <= (T_STEP == t_max) ? '0 : T_STEP + T_WIDTH'(1);
    end
  end

`ifdef SNN_LAYER_SEQ_TIMEOUT_EN
  logic [WDT_WIDTH-1:0] wdt;
  logic                 wdt_sat, err_q;

  assign wdt_sat    = (state == S_WAIT) && (&wdt);
  assign force_zero = wdt_sat;
  assign ERR        = err_q;

  // gather-phase watchdog; saturation closes the step and latches ERR
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      wdt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == S_FIRE)                 wdt <= '0;
      else if (state == S_WAIT && !(&wdt)) wdt <= wdt + WDT_WIDTH'(1);
      if (wdt_sat) err_q <= 1'b1;
    end
  end
`else
  // no watchdog: gather waits forever, ERR stays low (WDT_WIDTH only sizes the counter)
  assign force_zero = 1'b0;
  assign ERR        = (WDT_WIDTH < 0);
`endif

  snn_out_buf #(
    .IO_WIDTH (IO_WIDTH),
    .N_TILE   (N_TILE),
    .NEU      (NEU)
  ) u_out_buf (
    .gclk       (CLK),
    .grst_n     (RSTB),
    .clr        (state == S_FIRE),
    .cap        (state == S_WAIT),
    .force_zero (force_zero),
    .drain      (state == S_DRAIN),
    .out_ready  (OUT_READY),
    .req        (REQ),
    .neuron_out (NEURON_OUT),
    .all_done   (all_done),
    .out_valid  (OUT_VALID),
    .out_spike  (OUT_SPIKE),
    .last_acc   (last_acc)
  );

endmodule
